// File: rtl/dwa_therm_encoder.sv
// dwa_therm_encoder: 4-bit binary code to 15-element thermometer with
// data-weighted averaging rotation for the unary feedback DAC.
// Two-cycle latency: stage 1 captures code/pointer, stage 2 drives the
// element enables. Rotation is built only when DWA_EN is defined; otherwise
// the output is the LSB-aligned thermometer and the pointer stays at 0.
module dwa_therm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_code,
  input  logic        ptr_clr,
  output logic [14:0] therm_out,
  output logic        out_valid,
  output logic [3:0]  ptr_out
);

  localparam int unsigned NumElem = 15;
  localparam int unsigned CodeW   = 4;
  localparam int unsigned SumW    = CodeW + 1;

  logic [CodeW-1:0]   ptr_q, ptr_d;
  logic [CodeW-1:0]   code_s1_q;
  logic [CodeW-1:0]   ptr_s1_q, ptr_s1_d;
  logic               v_s1_q;
  logic [NumElem-1:0] therm_q, therm_d;
  logic               out_valid_q;

`ifdef DWA_EN
  logic [CodeW-1:0] eff_ptr_c;
  logic [SumW-1:0]  sum_c;

  // Effective pointer and modulo-15 advance by the accepted code
  always_comb begin
    eff_ptr_c = ptr_clr ? '0 : ptr_q;
    sum_c     = {1'b0, eff_ptr_c} + {1'b0, in_code};
    ptr_s1_d  = eff_ptr_c;
    ptr_d     = eff_ptr_c;
    if (in_valid) begin
      ptr_d = (sum_c >= SumW'(NumElem)) ? CodeW'(sum_c - SumW'(NumElem))
                                        : sum_c[CodeW-1:0];
    end
  end
`else
  logic unused_ptr_clr;

  // Rotation disabled: pointer tied to zero, clear pulse has no effect
  always_comb begin
    ptr_d          = '0;
    ptr_s1_d       = '0;
    unused_ptr_clr = ptr_clr;
  end
`endif

  logic [NumElem-1:0] base_c;

  // LSB-aligned run of code_s1 ones, rotated left by ptr_s1 within 15 bits
  always_comb begin
    base_c  = NumElem'((16'd1 << code_s1_q) - 16'd1);
    therm_d = (base_c << ptr_s1_q) | (base_c >> (4'd15 - ptr_s1_q));
  end

  // Stage 1 capture, pointer register and stage 2 output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      code_s1_q   <= '0;
      ptr_s1_q    <= '0;
      v_s1_q      <= 1'b0;
      therm_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      v_s1_q <= in_valid;
      if (in_valid) begin
        code_s1_q <= in_code;
        ptr_s1_q  <= ptr_s1_d;
      end
      out_valid_q <= v_s1_q;
      if (v_s1_q) begin
        therm_q <= therm_d;
      end
    end
  end

  assign therm_out = therm_q;
  assign out_valid = out_valid_q;
  assign ptr_out   = ptr_q;

endmodule

// File: tb/tb_dwa_therm_encoder.sv
// Self-checking bench for dwa_therm_encoder: directed vector table plus a
// randomized run, both feeding a scoreboard queue popped on out_valid.
module tb_dwa_therm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_code;
  logic        ptr_clr;
  logic [14:0] therm_out;
  logic        out_valid;
  logic [3:0]  ptr_out;

  dwa_therm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .ptr_clr   (ptr_clr),
    .therm_out (therm_out),
    .out_valid (out_valid),
    .ptr_out   (ptr_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        v;
    logic        clr;
    logic [3:0]  code;
    logic [14:0] therm;
    logic        ov;
    logic [3:0]  ptr;
  } vec_t;

  typedef struct {
    logic [14:0] therm;
    logic [3:0]  code;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        mv1      = 1'b0;
  int          mptr     = 0;
  logic [14:0] last     = '0;

  function automatic logic [14:0] model_therm(input int p, input int c);
    logic [14:0] t;
    t = '0;
    for (int i = 0; i < 15; i++) begin
      if (((i - p + 15) % 15) < c) t[i] = 1'b1;
    end
    return t;
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic clr,
                              input logic [3:0] code, input logic [14:0] th,
                              input logic ov, input logic [3:0] p);
    vec_t x;
    x.r = r; x.v = v; x.clr = clr; x.code = code;
    x.therm = th; x.ov = ov; x.ptr = p;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then check the DUT after the edge
  task automatic cyc(input logic r, input logic v, input logic clr, input logic [3:0] c);
    logic exp_ov;
    int   eff;
    exp_t e;
    rst      = r;
    in_valid = v;
    ptr_clr  = clr;
    in_code  = c;
    if (r) begin
      sbq.delete();
      mv1    = 1'b0;
      mptr   = 0;
      last   = '0;
      exp_ov = 1'b0;
    end else begin
      exp_ov = mv1;
`ifdef DWA_EN
      eff = clr ? 0 : mptr;
`else
      eff = 0;
`endif
      if (v) begin
        e.therm = model_therm(eff, int'(c));
        e.code  = c;
        sbq.push_back(e);
        mptr = (eff + int'(c)) % 15;
        mv1  = 1'b1;
      end else begin
        mptr = eff;
        mv1  = 1'b0;
      end
`ifndef DWA_EN
      mptr = 0;
`endif
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("ptr_out", 32'(ptr_out), 32'(mptr));
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got out_valid=1, expected no pending code at %0t", $time);
      end else begin
        e = sbq.pop_front();
        check("therm", 32'(therm_out), 32'(e.therm));
        check("popcount", 32'($countones(therm_out)), 32'(e.code));
        last = e.therm;
      end
    end else begin
      check("therm_hold", 32'(therm_out), 32'(last));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_code = '0; ptr_clr = 1'b0;

`ifdef DWA_EN
    //            r  v  clr code   therm     ov  ptr
    tbl.push_back(mk(1, 0, 0, 4'd0,  15'h0000, 0, 4'd0));
    tbl.push_back(mk(0, 1, 0, 4'd3,  15'h0000, 0, 4'd3));
    tbl.push_back(mk(0, 1, 0, 4'd5,  15'h0007, 1, 4'd8));
    tbl.push_back(mk(0, 1, 0, 4'd10, 15'h00F8, 1, 4'd3));
    tbl.push_back(mk(0, 1, 0, 4'd15, 15'h7F07, 1, 4'd3));
    tbl.push_back(mk(0, 1, 0, 4'd0,  15'h7FFF, 1, 4'd3));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h0000, 1, 4'd3));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h0000, 0, 4'd3));
    tbl.push_back(mk(0, 1, 0, 4'd8,  15'h0000, 0, 4'd11));
    tbl.push_back(mk(0, 1, 1, 4'd4,  15'h07F8, 1, 4'd4));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h000F, 1, 4'd4));
    tbl.push_back(mk(0, 1, 0, 4'd2,  15'h000F, 0, 4'd6));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h0030, 1, 4'd6));
    tbl.push_back(mk(0, 0, 1, 4'd0,  15'h0030, 0, 4'd0));
    tbl.push_back(mk(0, 1, 0, 4'd6,  15'h0030, 0, 4'd6));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h003F, 1, 4'd6));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h003F, 0, 4'd6));
    tbl.push_back(mk(0, 1, 0, 4'd2,  15'h003F, 0, 4'd8));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h00C0, 1, 4'd8));
    tbl.push_back(mk(0, 1, 0, 4'd9,  15'h00C0, 0, 4'd2));
    tbl.push_back(mk(1, 0, 0, 4'd0,  15'h0000, 0, 4'd0));
    tbl.push_back(mk(0, 1, 0, 4'd1,  15'h0000, 0, 4'd1));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h0001, 1, 4'd1));
`else
    tbl.push_back(mk(1, 0, 0, 4'd0,  15'h0000, 0, 4'd0));
    tbl.push_back(mk(0, 1, 0, 4'd3,  15'h0000, 0, 4'd0));
    tbl.push_back(mk(0, 1, 0, 4'd5,  15'h0007, 1, 4'd0));
    tbl.push_back(mk(0, 1, 0, 4'd10, 15'h001F, 1, 4'd0));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h03FF, 1, 4'd0));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h03FF, 0, 4'd0));
    tbl.push_back(mk(0, 1, 1, 4'd4,  15'h03FF, 0, 4'd0));
    tbl.push_back(mk(0, 1, 0, 4'd15, 15'h000F, 1, 4'd0));
    tbl.push_back(mk(0, 1, 0, 4'd0,  15'h7FFF, 1, 4'd0));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h0000, 1, 4'd0));
    tbl.push_back(mk(0, 1, 0, 4'd9,  15'h0000, 0, 4'd0));
    tbl.push_back(mk(1, 0, 0, 4'd0,  15'h0000, 0, 4'd0));
    tbl.push_back(mk(0, 1, 0, 4'd1,  15'h0000, 0, 4'd0));
    tbl.push_back(mk(0, 0, 0, 4'd0,  15'h0001, 1, 4'd0));
    tbl.push_back(mk(0, 0, 1, 4'd0,  15'h0001, 0, 4'd0));
`endif

    foreach (tbl[k]) begin
      cyc(tbl[k].r, tbl[k].v, tbl[k].clr, tbl[k].code);
      check("tbl_therm", 32'(therm_out), 32'(tbl[k].therm));
      check("tbl_out_valid", 32'(out_valid), 32'(tbl[k].ov));
      check("tbl_ptr_out", 32'(ptr_out), 32'(tbl[k].ptr));
    end

    // Randomized traffic with occasional clears and resets
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)));
    end

    // Back-to-back codes including both extremes, then drain
    for (int c = 15; c >= 0; c--) cyc(1'b0, 1'b1, 1'b0, 4'(c));
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 4'd0);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
